// File: rtl/gnn_0_example_save_wr_master.sv
// AXI4 write master for the save path. It takes a start address and a byte
// count, splits the transfer into bursts that never cross a 4KB page, and
// passes the upstream stream straight through to the W channel. Burst lengths
// are queued in a small FIFO so W beats only start after their AW handshake.
module gnn_0_example_save_wr_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_BURST        = 16,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
  output logic                            ctrl_done,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  // Beat counters hold ceil(size/64), which needs one bit more than size/64.
  localparam int BW = C_XFER_SIZE_WIDTH - 6 + 1;
  // Burst lengths are 1..256 beats.
  localparam int LW = 9;
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int PW = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, RUN, WAIT_B, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0] aw_addr_reg;
  logic [BW-1:0]                 aw_rem_reg;
  logic [BW-1:0]                 w_rem_reg;
  logic [OW-1:0]                 outstanding_reg, outstanding_next;
  logic [LW-1:0]                 w_beat_reg;
  logic [LW-1:0]                 fifo_mem [C_MAX_OUTSTANDING];
  logic [PW-1:0]                 fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [OW-1:0]                 fifo_cnt_reg, fifo_cnt_next;

  logic [BW-1:0] total_beats;
  logic [6:0]    beats_to_4k;
  logic [BW-1:0] len_wide;
  logic [LW-1:0] burst_len;
  logic [LW-1:0] fifo_head;
  logic          w_active;
  logic          w_last_beat;
  logic          aw_hs, w_hs, b_hs;
  logic          fifo_push, fifo_pop;

  // Partial last beat rounds up to a whole beat.
  assign total_beats = BW'(ctrl_xfer_size_in_bytes[C_XFER_SIZE_WIDTH-1:6])
                     + BW'(|ctrl_xfer_size_in_bytes[5:0]);

  // Beats left before the current address reaches the next 4KB page (1..64).
  assign beats_to_4k = 7'd64 - {1'b0, aw_addr_reg[11:6]};

  // Burst length is the smallest of remaining beats, max burst and page room.
  always_comb begin
    len_wide = aw_rem_reg;
    if (len_wide > BW'(C_MAX_BURST)) len_wide = BW'(C_MAX_BURST);
    if (len_wide > BW'(beats_to_4k)) len_wide = BW'(beats_to_4k);
  end
  assign burst_len = len_wide[LW-1:0];

  // AW channel: address and length only change on a handshake, so they are
  // naturally stable while the slave stalls.
  assign m_axi_awvalid = (state_reg == RUN) && (aw_rem_reg != '0)
                      && (outstanding_reg < OW'(C_MAX_OUTSTANDING));
  assign m_axi_awaddr  = aw_addr_reg;
  assign m_axi_awlen   = 8'(burst_len - LW'(1));

  // W channel is a pure pass-through gated by the burst FIFO.
  assign fifo_head     = fifo_mem[fifo_rd_ptr_reg];
  assign w_active      = (fifo_cnt_reg != '0) && (w_rem_reg != '0);
  assign w_last_beat   = (w_beat_reg == fifo_head - LW'(1));
  assign m_axi_wvalid  = s_axis_tvalid & w_active;
  assign s_axis_tready = m_axi_wready & w_active;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_active & w_last_beat;

  assign m_axi_bready  = (state_reg == RUN) || (state_reg == WAIT_B);
  assign ctrl_done     = (state_reg == DONE);

  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready & (outstanding_reg != '0);
  assign fifo_push = aw_hs;
  assign fifo_pop  = w_hs & w_last_beat;

  // Outstanding-burst and FIFO occupancy bookkeeping; simultaneous up/down cancel.
  always_comb begin
    outstanding_next = outstanding_reg;
    fifo_cnt_next    = fifo_cnt_reg;
    if (aw_hs && !b_hs) outstanding_next = outstanding_reg + OW'(1);
    else if (!aw_hs && b_hs) outstanding_next = outstanding_reg - OW'(1);
    if (fifo_push && !fifo_pop) fifo_cnt_next = fifo_cnt_reg + OW'(1);
    else if (!fifo_push && fifo_pop) fifo_cnt_next = fifo_cnt_reg - OW'(1);
  end

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ctrl_start) state_next = (total_beats == '0) ? DONE : RUN;
      RUN:     if ((aw_rem_reg == '0) && (w_rem_reg == '0)) state_next = WAIT_B;
      WAIT_B:  if (outstanding_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Transfer counters, address generator and burst FIFO pointers.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      aw_addr_reg     <= '0;
      aw_rem_reg      <= '0;
      w_rem_reg       <= '0;
      outstanding_reg <= '0;
      w_beat_reg      <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_cnt_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      fifo_cnt_reg    <= fifo_cnt_next;
      if (state_reg == IDLE && ctrl_start) begin
        aw_addr_reg <= ctrl_addr_offset;
        aw_rem_reg  <= total_beats;
        w_rem_reg   <= total_beats;
      end
      if (aw_hs) begin
        aw_addr_reg     <= aw_addr_reg + (C_M_AXI_ADDR_WIDTH'(burst_len) << 6);
        aw_rem_reg      <= aw_rem_reg - BW'(burst_len);
        fifo_wr_ptr_reg <= (fifo_wr_ptr_reg == PW'(C_MAX_OUTSTANDING - 1))
                         ? '0 : fifo_wr_ptr_reg + PW'(1);
      end
      if (w_hs) begin
        w_rem_reg <= w_rem_reg - BW'(1);
        if (w_last_beat) begin
          w_beat_reg      <= '0;
          fifo_rd_ptr_reg <= (fifo_rd_ptr_reg == PW'(C_MAX_OUTSTANDING - 1))
                           ? '0 : fifo_rd_ptr_reg + PW'(1);
        end else begin
          w_beat_reg <= w_beat_reg + LW'(1);
        end
      end
    end
  end

  // Burst-length storage; validity is tracked by the pointers, not the contents.
  always_ff @(posedge aclk) begin
    if (fifo_push) fifo_mem[fifo_wr_ptr_reg] <= burst_len;
  end

endmodule

// File: tb/tb_gnn_0_example_save_wr_master.sv
// Self-checking bench for the save-path AXI write master: directed table of
// transfers plus randomized handshakes, checked against a burst-splitting model.
module tb_gnn_0_example_save_wr_master;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [SW-1:0] ctrl_xfer_size_in_bytes = '0;
  logic          ctrl_done;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  int n_cmp = 0;
  int n_fail = 0;

  gnn_0_example_save_wr_master dut (
    .aclk                    (aclk),
    .areset                  (areset),
    .ctrl_start              (ctrl_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_done               (ctrl_done),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata),
    .m_axi_awvalid           (m_axi_awvalid),
    .m_axi_awready           (m_axi_awready),
    .m_axi_awaddr            (m_axi_awaddr),
    .m_axi_awlen             (m_axi_awlen),
    .m_axi_wvalid            (m_axi_wvalid),
    .m_axi_wready            (m_axi_wready),
    .m_axi_wdata             (m_axi_wdata),
    .m_axi_wstrb             (m_axi_wstrb),
    .m_axi_wlast             (m_axi_wlast),
    .m_axi_bvalid            (m_axi_bvalid),
    .m_axi_bready            (m_axi_bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] size;
    bit          rnd;
    bit          bhold;
    bit          spurious;
    int          exp_bursts;
    int          exp_first_len;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned seed, input int idx);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++)
      d[i*32 +: 32] = seed ^ (32'(idx) * 32'h9E37_79B1) ^ 32'(i);
    return d;
  endfunction

  task automatic idle_inputs();
    ctrl_start    = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
    chk({tag, "_wvalid"},  64'(m_axi_wvalid),  64'd0);
    chk({tag, "_wlast"},   64'(m_axi_wlast),   64'd0);
    chk({tag, "_bready"},  64'(m_axi_bready),  64'd0);
    chk({tag, "_tready"},  64'(s_axis_tready), 64'd0);
    chk({tag, "_done"},    64'(ctrl_done),     64'd0);
  endtask

  // One transfer: drives start, random handshakes and a B responder, and checks
  // every AW/W/B event against the burst list computed from addr/size.
  task automatic run_xfer(input logic [63:0] addr, input logic [31:0] size,
                          input bit rnd, input bit bhold, input bit spurious,
                          input int abort_at,
                          output int aw_n, output int first_len, output int done_cyc);
    logic [63:0] m_addr[$];
    int          m_len[$];
    longint      rem, a, to4k, l;
    int          total, w_n, b_n, last_n, w_in_burst, done_n;
    int unsigned seed;
    bit          prev_stall, finished, aborted, exp_last;
    logic [63:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [DW-1:0] exp_data;

    rem   = (longint'(size) + 63) / 64;
    total = int'(rem);
    a     = longint'(addr);
    while (rem > 0) begin
      to4k = (4096 - (a % 4096)) / 64;
      l = rem;
      if (l > 16) l = 16;
      if (l > to4k) l = to4k;
      m_addr.push_back(64'(a));
      m_len.push_back(int'(l));
      a   += l * 64;
      rem -= l;
    end

    seed = $urandom;
    aw_n = 0; w_n = 0; b_n = 0; last_n = 0; w_in_burst = 0; done_n = 0;
    first_len = -1; done_cyc = -1;
    prev_stall = 1'b0; finished = 1'b0; aborted = 1'b0;
    prev_awaddr = '0; prev_awlen = '0;

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge aclk);
      if (cyc == abort_at) begin
        areset = 1'b0;
        ctrl_start = 1'b0;
        s_axis_tvalid = 1'b1; m_axi_wready = 1'b1; m_axi_awready = 1'b1; m_axi_bvalid = 1'b1;
        #1;
        check_reset_outputs("abort_async");
        repeat (3) @(negedge aclk);
        #1;
        check_reset_outputs("abort_held");
        areset = 1'b1;
        idle_inputs();
        finished = 1'b1;
        aborted  = 1'b1;
      end else begin
        ctrl_start = (cyc == 0) || (spurious && cyc == 3);
        ctrl_addr_offset = (cyc == 0) ? addr : ({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFC0);
        ctrl_xfer_size_in_bytes = (cyc == 0) ? size : 32'($urandom_range(64, 4096));
        m_axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_tvalid = (w_n < total) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        s_axis_tdata  = pat(seed, w_n);
        m_axi_bvalid  = (last_n > b_n) && !(bhold && cyc < 200)
                      && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        #1;

        if (bhold && cyc == 200) begin
          chk("hold_aw_count", 64'(aw_n), 64'd4);
          chk("hold_awvalid", 64'(m_axi_awvalid), 64'd0);
        end
        if (m_axi_awvalid)
          chk("aw_outstanding_below_max", 64'((aw_n - b_n) < 4), 64'd1);
        if (prev_stall) begin
          chk("aw_hold_valid", 64'(m_axi_awvalid), 64'd1);
          chk("aw_hold_addr", m_axi_awaddr, prev_awaddr);
          chk("aw_hold_len", 64'(m_axi_awlen), 64'(prev_awlen));
        end
        if ((s_axis_tvalid && s_axis_tready) || (m_axi_wvalid && m_axi_wready))
          chk("consume_eq_w", 64'(s_axis_tvalid && s_axis_tready), 64'(m_axi_wvalid && m_axi_wready));

        if (m_axi_wvalid && m_axi_wready) begin
          if (last_n >= m_len.size()) begin
            n_cmp++; n_fail++;
            $display("FAIL w_extra_beat: beat %0d seen, required at most %0d beats", w_n, total);
          end else begin
            chk("w_after_aw", 64'(last_n < aw_n), 64'd1);
            exp_data = pat(seed, w_n);
            n_cmp++;
            if (m_axi_wdata !== exp_data) begin
              n_fail++;
              $display("FAIL wdata beat %0d: got %h required %h", w_n, m_axi_wdata[63:0], exp_data[63:0]);
            end
            exp_last = (w_in_burst == m_len[last_n] - 1);
            chk("wlast", 64'(m_axi_wlast), 64'(exp_last));
            chk("wstrb_ones", 64'(&m_axi_wstrb), 64'd1);
            w_n++;
            if (exp_last) begin last_n++; w_in_burst = 0; end
            else w_in_burst++;
          end
        end

        if (m_axi_awvalid && m_axi_awready) begin
          if (aw_n < m_addr.size()) begin
            chk("awaddr", m_axi_awaddr, m_addr[aw_n]);
            chk("awlen", 64'(m_axi_awlen), 64'(m_len[aw_n] - 1));
          end else begin
            n_cmp++; n_fail++;
            $display("FAIL aw_extra: burst %0d seen, required %0d bursts", aw_n + 1, m_addr.size());
          end
          if (aw_n == 0) first_len = int'(m_axi_awlen);
          aw_n++;
        end
        prev_stall  = m_axi_awvalid && !m_axi_awready;
        prev_awaddr = m_axi_awaddr;
        prev_awlen  = m_axi_awlen;

        if (m_axi_bvalid && m_axi_bready) b_n++;
        if (done_n > 0)
          chk("idle_after_done", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
        if (ctrl_done) begin
          done_n++;
          done_cyc = cyc;
          chk("done_after_all_b", 64'(b_n), 64'(m_addr.size()));
        end
        if (done_n > 0 && cyc >= done_cyc + 2) finished = 1'b1;
      end
    end

    if (aborted) begin
      $display("xfer addr=%h size=%0d aborted after %0d W beats, data intact so far", addr, size, w_n);
    end else begin
      if (done_n == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: no ctrl_done within cycle budget (addr=%h size=%0d)", addr, size);
      end
      chk("done_count", 64'(done_n), 64'd1);
      chk("aw_count", 64'(aw_n), 64'(m_addr.size()));
      chk("w_count", 64'(w_n), 64'(total));
      chk("b_count", 64'(b_n), 64'(m_addr.size()));
      $display("xfer addr=%h size=%0d bursts=%0d beats=%0d done_cyc=%0d", addr, size, aw_n, w_n, done_cyc);
    end
    idle_inputs();
  endtask

  initial begin
    int aw_n, first_len, done_cyc;
    logic [63:0] raddr;
    logic [31:0] rsize;

    // Reset state.
    idle_inputs();
    areset = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_reset_outputs("reset");
    areset = 1'b1;

    vecs[0] = '{64'h1000,  32'd1024, 1'b0, 1'b0, 1'b1, 1, 15, -1};
    vecs[1] = '{64'h2000,  32'd100,  1'b0, 1'b0, 1'b0, 1, 1,  -1};
    vecs[2] = '{64'h3000,  32'd0,    1'b0, 1'b0, 1'b0, 0, -1, 1};
    vecs[3] = '{64'h0FC0,  32'd256,  1'b0, 1'b0, 1'b0, 2, 0,  -1};
    vecs[4] = '{64'h10000, 32'd8192, 1'b0, 1'b1, 1'b0, 8, 15, -1};
    vecs[5] = '{64'h5F80,  32'd65,   1'b1, 1'b0, 1'b0, 1, 1,  -1};
    vecs[6] = '{64'h7E40,  32'd2048, 1'b1, 1'b0, 1'b1, 3, 6,  -1};

    for (int i = 0; i < 7; i++) begin
      run_xfer(vecs[i].addr, vecs[i].size, vecs[i].rnd, vecs[i].bhold, vecs[i].spurious,
               -1, aw_n, first_len, done_cyc);
      chk("vec_bursts", 64'(aw_n), 64'(vecs[i].exp_bursts));
      if (vecs[i].exp_bursts > 0)
        chk("vec_first_awlen", 64'(first_len), 64'(vecs[i].exp_first_len));
      if (vecs[i].exp_done_cyc >= 0)
        chk("vec_done_latency", 64'(done_cyc), 64'(vecs[i].exp_done_cyc));
    end

    // Randomized transfers with random handshakes.
    for (int i = 0; i < 6; i++) begin
      raddr = 64'($urandom) & 64'h0003_FFC0;
      rsize = 32'($urandom_range(0, 3000));
      run_xfer(raddr, rsize, 1'b1, 1'b0, 1'b1, -1, aw_n, first_len, done_cyc);
    end

    // Mid-transfer reset, then a fresh transfer right after release.
    run_xfer(64'h0002_0FC0, 32'd4096, 1'b1, 1'b0, 1'b0, 40, aw_n, first_len, done_cyc);
    chk("abort_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    run_xfer(64'h0003_0F00, 32'd1500, 1'b1, 1'b0, 1'b0, -1, aw_n, first_len, done_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gnn_0_example_save_wr_master.md
GNN_0_EXAMPLE_SAVE_WR_MASTER -- requirements
Module: gnn_0_example_save_wr_master

Interface
- REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64: AXI address width.
- REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 512: AXI and stream data width; one beat is 64 bytes.
- REQ-003 SHALL have parameter C_XFER_SIZE_WIDTH, default 32: byte-count width.
- REQ-004 SHALL have parameter C_MAX_BURST, default 16: maximum beats per burst.
- REQ-005 SHALL have parameter C_MAX_OUTSTANDING, default 4: maximum AW bursts issued without a matching B response.
- REQ-006 SHALL have ports (one clock; reset is asynchronous and active-low):
  aclk  in  1  clock
  areset  in  1  asynchronous active-low reset
  ctrl_start  in  1  start pulse
  ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  byte address; 64B aligned
  ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  transfer length in bytes
  ctrl_done  out  1  one-cycle completion pulse
  s_axis_tvalid  in  1  upstream save-data valid
  s_axis_tready  out  1  upstream ready
  s_axis_tdata  in  C_M_AXI_DATA_WIDTH  upstream data
  m_axi_awvalid/awready/awaddr/awlen  out/in/out/out  1/1/ADDR/8  AXI write address
  m_axi_wvalid/wready/wdata/wstrb/wlast  out/in/out/out/out  1/1/DATA/DATA/8/1  AXI write data
  m_axi_bvalid/bready  in/out  1/1  AXI write response

Function
- REQ-007 SHALL use states IDLE, RUN, WAIT_B, DONE.
- REQ-008 In IDLE, ctrl_start=1 SHALL latch the address and set total_beats = ceil(size/64); the next state SHALL be RUN, or DONE if total_beats=0.
- REQ-009 ctrl_start SHALL be ignored in every state except IDLE.
- REQ-010 Burst length SHALL be min(remaining AW beats, C_MAX_BURST, beats up to the next 4KB boundary).
- REQ-011 awlen SHALL equal length-1.
- REQ-012 awaddr SHALL advance by length*64 on each AW handshake.
- REQ-013 awvalid SHALL be asserted in RUN while AW beats remain and outstanding < C_MAX_OUTSTANDING.
- REQ-014 awaddr and awlen SHALL be held stable while awvalid=1 and awready=0.
- REQ-015 Each accepted AW length SHALL be pushed into a length FIFO of depth C_MAX_OUTSTANDING.
- REQ-016 The W path SHALL pop lengths from this FIFO, so W beats of burst n never precede the AW handshake of burst n.
- REQ-017 W is a combinational pass-through:
  - wvalid = s_axis_tvalid & w_active
  - s_axis_tready = m_axi_wready & w_active
  - wdata = s_axis_tdata
  - wstrb = all ones
- REQ-018 wlast SHALL be 1 exactly on the final beat of each burst.
- REQ-019 w_active = 1 while the FIFO is non-empty and W beats remain.
- REQ-020 outstanding SHALL increment on each AW handshake and decrement on each bvalid&bready; a simultaneous increment and decrement SHALL leave it unchanged.
- REQ-021 bready SHALL be 1 in RUN and WAIT_B, and 0 otherwise.
- REQ-022 RUN SHALL transition to WAIT_B when all AW and all W beats are complete.
- REQ-023 WAIT_B SHALL transition to DONE when outstanding reaches 0, including on the cycle the final B arrives.
- REQ-024 DONE SHALL assert ctrl_done for exactly one cycle and then return to IDLE.
- REQ-025 Beat counters SHALL be C_XFER_SIZE_WIDTH-6+1 bits wide; a size that is not a multiple of 64 SHALL round up to a full beat.
- REQ-026 Upstream data SHALL never be consumed outside w_active, and no beat SHALL be dropped or duplicated under any pattern of tvalid/wready stalls.

Reset
- REQ-027 areset=0 SHALL immediately force IDLE and clear all counters and the FIFO.
- REQ-028 During reset, awvalid, wvalid, wlast, bready, s_axis_tready and ctrl_done SHALL all be 0.
- REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no ctrl_done; operation SHALL resume on the first clock edge after release.

Verification
- REQ-030 Size 1024B at 0x1000, all ready/valid held at 1 -> one AW with awaddr=0x1000 and awlen=15; 16 W beats with wlast on beat 16; one ctrl_done after the B response.
- REQ-031 Size 100B -> awlen=1, 2 beats, 1 burst.
- REQ-032 Size 0 -> ctrl_done one cycle after start; no AXI activity.
- REQ-033 Address 0x0FC0, size 256B -> first burst awaddr=0x0FC0 with awlen=0; second burst awaddr=0x1000 with awlen=2; no burst crosses 4KB.
- REQ-034 Size 8KB, bvalid held low -> awvalid stops after 4 outstanding bursts; AW resumes as each B returns; ctrl_done fires once.
- REQ-035 Random tvalid, wready and awready plus a mid-transfer reset -> wdata sequence equals the tdata sequence with no loss; after reset, all outputs are 0 and a new transfer completes correctly.
